// File: rtl/mem_access_seq.sv
// Memory-port sequencer for the multicycle datapath.
// Steps one transaction through address, latency wait and capture.
module mem_access_seq #(
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    input  logic [1:0] req_src,
    input  logic       req_write,
    input  logic       flush,
    output logic [1:0] mux_iord_control,
    output logic       mem_wr,
    output logic       ir_wr,
    output logic       mdr_wr,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] WaitLd = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic             HasWait = (WAIT_CYCLES > 0);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       src_q;
    logic             write_q;
    logic             err_q;
    logic [1:0]       mux_q;
    logic             mem_wr_q;
    logic             ir_q;
    logic             mdr_q;
    logic             busy_q;
    logic             done_q;
    logic             err_out_q;

    logic             req_illegal;

    // Stores may only target the ALUOut or ALU-result address.
    always_comb begin
        req_illegal = req_write
                    && ((req_src == 2'b00) || (req_src == 2'b11));
    end

    // Transaction FSM; every output is registered alongside the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            src_q     <= 2'b00;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            mux_q     <= 2'b00;
            mem_wr_q  <= 1'b0;
            ir_q      <= 1'b0;
            mdr_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_out_q <= 1'b0;
        end else begin
            mem_wr_q  <= 1'b0;
            ir_q      <= 1'b0;
            mdr_q     <= 1'b0;
            done_q    <= 1'b0;
            err_out_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        src_q   <= req_src;
                        write_q <= req_write;
                        busy_q  <= 1'b1;
                        if (req_illegal) begin
                            err_q     <= 1'b1;
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            err_out_q <= 1'b1;
                            mux_q     <= 2'b00;
                        end else begin
                            err_q    <= 1'b0;
                            state_q  <= S_ACCESS;
                            mux_q    <= req_src;
                            mem_wr_q <= req_write;
                        end
                    end
                end
                S_ACCESS: begin
                    if (write_q) begin
                        // Write is already committed; flush cannot stop it.
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        err_out_q <= err_q;
                        mux_q     <= 2'b00;
                    end else if (flush) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        mux_q   <= 2'b00;
                    end else begin
                        cnt_q <= WaitLd;
                        if (HasWait) begin
                            state_q <= S_WAIT;
                        end else begin
                            state_q <= S_CAPTURE;
                            ir_q    <= (src_q == 2'b00);
                            mdr_q   <= (src_q != 2'b00);
                        end
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        mux_q   <= 2'b00;
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                        if (cnt_q == CntOne) begin
                            state_q <= S_CAPTURE;
                            ir_q    <= (src_q == 2'b00);
                            mdr_q   <= (src_q != 2'b00);
                        end
                    end
                end
                S_CAPTURE: begin
                    busy_q <= ~flush;
                    mux_q  <= 2'b00;
                    if (flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        err_out_q <= err_q;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    mux_q   <= 2'b00;
                end
            endcase
        end
    end

    // A flush in the capture cycle must still veto the register load.
    always_comb begin
        mux_iord_control = mux_q;
        mem_wr           = mem_wr_q;
        ir_wr            = ir_q & ~flush;
        mdr_wr           = mdr_q & ~flush;
        busy             = busy_q;
        done             = done_q;
        err              = err_out_q;
    end

endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: three instances with wait of 2, 0 and 3.
// Expected transactions are queued; per-instance monitors pop on completion.
module tb_mem_access_seq;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] rv, rw, fl;
    logic [1:0] rs  [3];
    logic [1:0] mux [3];
    logic [2:0] mw, irw, mdrw, bsy, dn, er;

    always #5 clk = ~clk;

    mem_access_seq #(.WAIT_CYCLES(2), .CNT_W(4)) u0 (
        .clk(clk), .reset_n(reset_n), .req_valid(rv[0]),
        .req_src(rs[0]), .req_write(rw[0]), .flush(fl[0]),
        .mux_iord_control(mux[0]), .mem_wr(mw[0]), .ir_wr(irw[0]),
        .mdr_wr(mdrw[0]), .busy(bsy[0]), .done(dn[0]), .err(er[0])
    );

    mem_access_seq #(.WAIT_CYCLES(0), .CNT_W(4)) u1 (
        .clk(clk), .reset_n(reset_n), .req_valid(rv[1]),
        .req_src(rs[1]), .req_write(rw[1]), .flush(fl[1]),
        .mux_iord_control(mux[1]), .mem_wr(mw[1]), .ir_wr(irw[1]),
        .mdr_wr(mdrw[1]), .busy(bsy[1]), .done(dn[1]), .err(er[1])
    );

    mem_access_seq #(.WAIT_CYCLES(3), .CNT_W(4)) u2 (
        .clk(clk), .reset_n(reset_n), .req_valid(rv[2]),
        .req_src(rs[2]), .req_write(rw[2]), .flush(fl[2]),
        .mux_iord_control(mux[2]), .mem_wr(mw[2]), .ir_wr(irw[2]),
        .mdr_wr(mdrw[2]), .busy(bsy[2]), .done(dn[2]), .err(er[2])
    );

    typedef struct {
        bit         done;
        bit         err;
        int         ir;
        int         mdr;
        int         mem;
        logic [1:0] mux;
        int         len;
        int         sidx;
        bit         stable;
    } txn_t;

    txn_t exp_q [3][$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(string name, int inst, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s u%0d: got %0d expected %0d",
                     name, inst, act, exp);
        end
    endtask

    task automatic expect_txn(int i, bit d, bit e, int ir, int mdr,
                              int mem, logic [1:0] m, int len, int sidx);
        txn_t t;
        t.done = d;   t.err = e;   t.ir = ir;    t.mdr = mdr;
        t.mem = mem;  t.mux = m;   t.len = len;  t.sidx = sidx;
        t.stable = 1'b1;
        exp_q[i].push_back(t);
    endtask

    task automatic compare(int i, txn_t o);
        txn_t e;
        if (exp_q[i].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_txn u%0d: got len %0d expected none",
                     i, o.len);
        end else begin
            e = exp_q[i].pop_front();
            chk("done",   i, int'(o.done),   int'(e.done));
            chk("err",    i, int'(o.err),    int'(e.err));
            chk("ir_cnt", i, o.ir,           e.ir);
            chk("mdr_cnt",i, o.mdr,          e.mdr);
            chk("mem_cnt",i, o.mem,          e.mem);
            chk("mux",    i, int'(o.mux),    int'(e.mux));
            chk("busy_len", i, o.len,        e.len);
            chk("strobe_cyc", i, o.sidx,     e.sidx);
            chk("mux_stable", i, int'(o.stable), int'(e.stable));
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_mon
        txn_t o;
        bit   act = 1'b0;
        always @(negedge clk) begin
            chk("ir_mdr_excl", g, int'(irw[g] & mdrw[g]), 0);
            chk("memwr_excl", g, int'(mw[g] & (irw[g] | mdrw[g])), 0);
            chk("err_wo_done", g, int'(er[g] & ~dn[g]), 0);
            if (bsy[g]) begin
                if (!act) begin
                    act      = 1'b1;
                    o        = '{default: 0};
                    o.mux    = mux[g];
                    o.stable = 1'b1;
                end
                o.len++;
                if (irw[g])  o.ir++;
                if (mdrw[g]) o.mdr++;
                if (mw[g])   o.mem++;
                if (irw[g] | mdrw[g] | mw[g]) o.sidx = o.len;
                if (dn[g]) begin
                    o.done = 1'b1;
                    o.err  = er[g];
                    if (mux[g] != 2'b00) o.stable = 1'b0;
                end else if (mux[g] != o.mux) begin
                    o.stable = 1'b0;
                end
            end else if (act) begin
                act = 1'b0;
                compare(g, o);
            end
        end
    end

    // Cycle 0 is the cycle req_valid is presented.
    task automatic run(int i, logic [1:0] src, bit wr, int flush_at,
                       bit tog, int ncyc);
        rv[i] = 1'b1;
        rs[i] = src;
        rw[i] = wr;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk);
            #1;
            rv[i] = 1'b0;
            fl[i] = (k == flush_at);
            if (tog) begin
                rs[i] = ~rs[i];
                rw[i] = ~rw[i];
            end
        end
        fl[i] = 1'b0;
    endtask

    function automatic int outs(int i);
        return int'({bsy[i], mux[i], mw[i], irw[i], mdrw[i], dn[i], er[i]});
    endfunction

    initial begin
        reset_n = 1'b0;
        rv = 3'b001;
        rw = '0;
        fl = '0;
        for (int i = 0; i < 3; i++) rs[i] = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) chk("in_reset_outs", i, outs(i), 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) chk("post_reset_outs", i, outs(i), 0);
        rv = '0;
        @(posedge clk);
        #1;

        // fetch, wait 2
        expect_txn(0, 1, 0, 1, 0, 0, 2'd0, 5, 4);
        run(0, 2'd0, 0, 0, 0, 7);
        // fetch with requester toggling src/write every cycle
        expect_txn(0, 1, 0, 1, 0, 0, 2'd0, 5, 4);
        run(0, 2'd0, 0, 0, 1, 7);
        // store via ALU result
        expect_txn(0, 1, 0, 0, 0, 1, 2'd2, 2, 1);
        run(0, 2'd2, 1, 0, 0, 4);
        // illegal store from PC
        expect_txn(0, 1, 1, 0, 0, 0, 2'd0, 1, 0);
        run(0, 2'd0, 1, 0, 0, 3);
        // read flushed in ACCESS
        expect_txn(0, 0, 0, 0, 0, 0, 2'd2, 1, 0);
        run(0, 2'd2, 0, 1, 0, 3);
        // flush during DONE is ignored
        expect_txn(0, 1, 0, 0, 1, 0, 2'd1, 5, 4);
        run(0, 2'd1, 0, 5, 0, 7);

        // wait 0: ALUOut load then vector read accepted in cycle 4
        expect_txn(1, 1, 0, 0, 1, 0, 2'd1, 3, 2);
        expect_txn(1, 1, 0, 0, 1, 0, 2'd3, 3, 2);
        run(1, 2'd1, 0, 0, 0, 4);
        run(1, 2'd3, 0, 0, 0, 5);
        // illegal store from exception vector
        expect_txn(1, 1, 1, 0, 0, 0, 2'd0, 1, 0);
        run(1, 2'd3, 1, 0, 0, 3);
        // fetch flushed in CAPTURE
        expect_txn(1, 0, 0, 0, 0, 0, 2'd0, 2, 0);
        run(1, 2'd0, 0, 2, 0, 4);

        // wait 3: full read
        expect_txn(2, 1, 0, 0, 1, 0, 2'd2, 6, 5);
        run(2, 2'd2, 0, 0, 0, 8);
        // load flushed in second WAIT cycle
        expect_txn(2, 0, 0, 0, 0, 0, 2'd1, 3, 0);
        run(2, 2'd1, 0, 3, 0, 6);
        // flush during store: write still committed
        expect_txn(2, 1, 0, 0, 0, 1, 2'd1, 2, 1);
        run(2, 2'd1, 1, 1, 0, 4);

        // reset in WAIT abandons the read with no done
        expect_txn(0, 0, 0, 0, 0, 0, 2'd1, 1, 0);
        rv[0] = 1'b1;
        rs[0] = 2'd1;
        rw[0] = 1'b0;
        @(posedge clk);
        #1;
        rv[0] = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("reset_in_wait_outs", 0, outs(0), 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        for (int c = 0; c < 50; c++) begin
            if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() == 0)
                break;
            @(posedge clk);
        end
        for (int i = 0; i < 3; i++)
            chk("queue_drain", i, exp_q[i].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- Sequencer for the multicycle datapath's memory port.
- Accepts one memory transaction at a time from the main control FSM and drives the memory-address mux select. Address sources: PC, ALUOut register, live ALU result, exception-vector address.
- Counts memory latency, drives the memory write strobe, and pulses IR/MDR load enables at the capture cycle.
- Returns a one-cycle done pulse so the main FSM can stall on memory instead of hard-coding wait states.

Parameters:
- WAIT_CYCLES, 2, memory read latency in clock cycles between address presentation and valid data (legal 0..15).
- CNT_W, 4, width of the internal wait counter; must hold WAIT_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  1  transaction request; sampled only in IDLE.
- req_src  input  2  address source: 00 PC, 01 ALUOut, 10 ALU result, 11 exception vector.
- req_write  input  1  1 = store, 0 = read.
- flush  input  1  synchronous abort of an in-flight read.
- mux_iord_control  output  2  address mux select.
- mem_wr  output  1  memory write strobe.
- ir_wr  output  1  instruction register load enable.
- mdr_wr  output  1  memory data register load enable.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  high together with done for an illegal request.

Behaviour:
- Clocking and reset: one clock domain. reset_n low asynchronously forces IDLE, counter = 0, latched src/write = 0. All outputs are 0, including mux_iord_control = 00.
- Reset mid-transaction: abandons the transaction with no done pulse.
- All outputs are registered or decoded from registered state only. No combinational path from req_* to any output.
- States: IDLE, ACCESS, WAIT, CAPTURE, DONE.
- IDLE:
  - mux_iord_control = 00.
  - If req_valid = 1: latch req_src and req_write.
  - Legal request: go to ACCESS.
  - Illegal request (req_write = 1 with src 00 or 11): go to DONE with err set.
- ACCESS (1 cycle):
  - mux_iord_control = latched src.
  - Store: mem_wr = 1 for exactly this cycle, then DONE.
  - Read: load counter with WAIT_CYCLES. Go to WAIT if WAIT_CYCLES > 0, else CAPTURE.
- WAIT:
  - Select held; counter decrements each cycle.
  - Leave for CAPTURE on the cycle the counter reaches 1, so WAIT lasts exactly WAIT_CYCLES cycles.
- CAPTURE (1 cycle):
  - Select held.
  - src 00 asserts ir_wr; src 01/10/11 assert mdr_wr.
  - Next state is DONE.
- DONE (1 cycle):
  - done = 1 and err = latched error flag; select returns to 00.
  - Next state is IDLE.
  - A new request is accepted no earlier than the following IDLE cycle, so back-to-back transactions have one IDLE gap.
- Read latency: req sampled at edge N gives ACCESS at N+1, CAPTURE at N+1+WAIT_CYCLES+1, done at the cycle after CAPTURE.
- Store latency: done two cycles after acceptance.
- flush:
  - In ACCESS (read), WAIT or CAPTURE: next state is IDLE; suppresses ir_wr/mdr_wr in that cycle; no done.
  - Ignored in IDLE, in DONE, and during a store (write already committed).
- mux_iord_control is stable and glitch-free from ACCESS through CAPTURE. Requester changes to req_* after acceptance have no effect.
- ir_wr and mdr_wr are never asserted together. mem_wr is never asserted together with either.

Test Plan:
- Reset: hold reset_n = 0 with req_valid = 1, release -> all outputs 0 and state IDLE. Assert reset_n = 0 during WAIT -> outputs 0 immediately; no done afterwards.
- Fetch, WAIT_CYCLES = 2: req_src = 00, read at cycle 0 -> mux = 00 in cycles 1-4, ir_wr = 1 only in cycle 4, done = 1 in cycle 5, busy high cycles 1-5.
- Load from ALUOut, WAIT_CYCLES = 0: req_src = 01 -> mux = 01 in cycles 1-2, mdr_wr in cycle 2, done in cycle 3. Then a vector read (src 11) is accepted in cycle 4 with mux = 11.
- Store via ALU result: req_src = 10, req_write = 1 -> mem_wr = 1 only in cycle 1 with mux = 10, done in cycle 2, no ir_wr/mdr_wr. Store with src = 00 -> no mem_wr, done and err in cycle 1.
- Flush: load src = 01, WAIT_CYCLES = 3, flush = 1 in second WAIT cycle -> IDLE next cycle, mdr_wr and done never asserted. Flush during a store -> mem_wr still pulses and done arrives.
- Stability: toggle req_src/req_write every cycle during a fetch -> mux_iord_control stays 00 through CAPTURE; exactly one transaction completes.
